// File: rtl/uart_rx_if.sv
// Byte delivery bus of the UART receiver: the receiver (master) presents the
// holding register and the error pulses, the consumer (slave) drives ready.
//
// Handshake: a byte transfers on every rising clock edge where valid and
// ready are both high. Once valid rises, data is held stable until that
// transfer happens; ready is don't-care while valid is low. ferr, overrun
// and perr are single-cycle pulses and are not part of the handshake.
interface uart_rx_if;
  logic [7:0] data;
  logic       valid;
  logic       ready;
  logic       ferr;
  logic       overrun;
  logic       perr;

  modport master (
    output data,
    output valid,
    output ferr,
    output overrun,
    output perr,
    input  ready
  );

  modport slave (
    input  data,
    input  valid,
    input  ferr,
    input  overrun,
    input  perr,
    output ready
  );
endinterface

// File: rtl/uart_rx.sv
// uart_rx: 8N1 asynchronous serial receiver with 16x oversampling.
//
// The rx pin is double-flopped, a falling level seen in IDLE anchors the
// oversampling divider, and each bit is sampled near mid-bit. Completed
// bytes land in a one-entry holding register exposed through uart_rx_if
// (valid/ready), with single-cycle framing-error and overrun pulses.
//
// Optional feature macro: UART_RX_PARITY_EN
//   defined   - an even-parity bit follows the data bits (11-bit frame),
//               mismatch pulses perr on the stop-bit sample cycle.
//   undefined - 10-bit frame, perr tied low.
//
// state_dbg exposes the FSM state: 0 IDLE, 1 START, 2 DATA, 3 PARITY, 4 STOP.
module uart_rx #(
  parameter int From = 50000000,
  parameter int Baud = 115200
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       rx,
  uart_rx_if.master  bus,
  output logic [2:0] state_dbg
);

  // Oversampling divider: one tick every DIV clocks, 16 ticks per bit.
  localparam int DIV = From / (Baud * 16);
  localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

  if (DIV < 1) begin : g_bad_div
    $error("uart_rx: From/(Baud*16) must be at least 1");
  end

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t          state;
  logic            rx_meta;
  logic            rxs;
  logic [DW-1:0]   div_cnt;
  logic            tick;
  logic [3:0]      sc;
  logic [2:0]      bit_idx;
  logic [7:0]      shift;
  logic [7:0]      data_q;
  logic            valid_q;
  logic            ferr_q;
  logic            overrun_q;
  logic            start_det;
  logic            start_mid;
  logic            bit_mid;
  logic            accept;

`ifdef UART_RX_PARITY_EN
  logic            par_bit;
  logic            perr_q;
`endif

  // Start is a low level on the synchronized line while idle; in a break
  // condition this re-detects a start right after every stop-bit sample.
  assign start_det = (state == IDLE) && !rxs;
  assign tick      = (div_cnt == DIV_LAST);

  // START is entered at the start edge, so its mid-bit is 8 ticks in.
  // Every later state is entered at a mid-bit point, so its sample lands
  // a full 16 ticks later, which is where sc wraps from 15 back to 0.
  assign start_mid = tick && (sc == 4'd7);
  assign bit_mid   = tick && (sc == 4'd15);
  assign accept    = valid_q && bus.ready;

  // Two-flop synchronizer, preset high so reset looks like an idle line.
  always_ff @(posedge clock) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= rx;
      rxs     <= rx_meta;
    end
  end

  // Free-running tick divider, realigned to the start edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      div_cnt <= '0;
    end else if (start_det || tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + DW'(1);
    end
  end

  // Receive FSM with the holding register and registered flag pulses.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      sc        <= 4'd0;
      bit_idx   <= 3'd0;
      shift     <= 8'h00;
      data_q    <= 8'h00;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
      overrun_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit   <= 1'b0;
      perr_q    <= 1'b0;
`endif
    end else begin
      ferr_q    <= 1'b0;
      overrun_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_q    <= 1'b0;
`endif
      // Consumer takes the byte; a completion below may refill it at once.
      if (accept) begin
        valid_q <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (start_det) begin
            state <= START;
            sc    <= 4'd0;
          end
        end

        START: begin
          if (start_mid) begin
            sc <= 4'd0;
            if (rxs) begin
              // Glitch shorter than half a bit: quietly go back to idle.
              state <= IDLE;
            end else begin
              state   <= DATA;
              bit_idx <= 3'd0;
            end
          end else if (tick) begin
            sc <= sc + 4'd1;
          end
        end

        DATA: begin
          if (tick) begin
            sc <= sc + 4'd1;
          end
          if (bit_mid) begin
            // LSB arrives first, so right-shifting leaves it in bit 0.
            shift <= {rxs, shift[7:1]};
            if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state <= PARITY;
`else
              state <= STOP;
`endif
              sc <= 4'd0;
            end else begin
              bit_idx <= bit_idx + 3'd1;
            end
          end
        end

`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (tick) begin
            sc <= sc + 4'd1;
          end
          if (bit_mid) begin
            par_bit <= rxs;
            state   <= STOP;
            sc      <= 4'd0;
          end
        end
`endif

        STOP: begin
          if (tick) begin
            sc <= sc + 4'd1;
          end
          if (bit_mid) begin
            // Leave at mid-stop so a back-to-back start edge is not missed.
            state <= IDLE;
            sc    <= 4'd0;
`ifdef UART_RX_PARITY_EN
            // Even parity: data ones plus parity bit must be even.
            perr_q <= (^shift) ^ par_bit;
`endif
            if (!rxs) begin
              // Bad stop bit: the byte is dropped without touching the
              // holding register or the overrun flag.
              ferr_q <= 1'b1;
            end else if (!valid_q || bus.ready) begin
              data_q  <= shift;
              valid_q <= 1'b1;
            end else begin
              overrun_q <= 1'b1;
            end
          end
        end

        default: begin
          state <= IDLE;
          sc    <= 4'd0;
        end
      endcase
    end
  end

  assign bus.data    = data_q;
  assign bus.valid   = valid_q;
  assign bus.ferr    = ferr_q;
  assign bus.overrun = overrun_q;
`ifdef UART_RX_PARITY_EN
  assign bus.perr    = perr_q;
`else
  assign bus.perr    = 1'b0;
`endif
  assign state_dbg   = state;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at Div=1 (16 clocks per bit).
// Inputs change 1 ns after the rising edge; the monitor samples on the
// falling edge and the directed steps check outputs 1 ns after the rising
// edge, so nothing is read on the active edge.
module tb_uart_rx;
  localparam int FROM     = 1600000;
  localparam int BAUD     = 100000;
  localparam int BIT_CLKS = 16;

  // ---------------- clock / reset ----------------
  logic       clock = 1'b0;
  logic       reset;
  logic       rx;
  logic [2:0] state_dbg;

  always #5 clock = ~clock;

  uart_rx_if bus ();

  uart_rx #(
    .From (FROM),
    .Baud (BAUD)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .rx        (rx),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  // ---------------- bookkeeping ----------------
  int n_tests = 0;
  int n_fail  = 0;

  int n_valid_cyc  = 0;
  int n_ferr       = 0;
  int n_ovr        = 0;
  int n_perr       = 0;
  int n_perr_valid = 0;

  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];

  // Monitor: counts pulses and collects every accepted byte.
  always @(negedge clock) begin
    if (!reset) begin
      if (bus.valid) n_valid_cyc++;
      if (bus.valid && bus.ready) got_q.push_back(bus.data);
      if (bus.ferr) n_ferr++;
      if (bus.overrun) n_ovr++;
      if (bus.perr) n_perr++;
      if (bus.perr && bus.valid) n_perr_valid++;
    end
  end

  // ---------------- driver / check tasks ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clks(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic send_bit(input logic v);
    rx = v;
    clks(BIT_CLKS);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_v);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
`ifdef UART_RX_PARITY_EN
    send_bit(^b);
`endif
    send_bit(stop_v);
    rx = 1'b1;
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic send_frame_par(input logic [7:0] b, input logic pbit);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(pbit);
    send_bit(1'b1);
  endtask
`endif

  // Scoreboard: compare collected bytes against the expected queue.
  task automatic check_bytes(input string tag);
    logic [7:0] e;
    logic [7:0] g;
    chk({tag, "_count"}, got_q.size(), exp_q.size());
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = (got_q.size() > 0) ? got_q.pop_front() : 8'hxx;
      chk({tag, "_byte"}, g, e);
    end
    got_q.delete();
  endtask

  // ---------------- directed sequence ----------------
  int v0, f0, o0, p0, pv0;

  initial begin
    reset     = 1'b1;
    rx        = 1'b1;
    bus.ready = 1'b1;
    clks(3);

    // Reset state
    chk("rst_data", bus.data, 8'h00);
    chk("rst_valid", bus.valid, 1'b0);
    chk("rst_ferr", bus.ferr, 1'b0);
    chk("rst_overrun", bus.overrun, 1'b0);
    chk("rst_perr", bus.perr, 1'b0);
    chk("rst_state", state_dbg, 3'd0);
    reset = 1'b0;
    clks(5);

    // Good frames, consumer always ready
    v0 = n_valid_cyc; f0 = n_ferr; o0 = n_ovr;
    send_frame(8'h55, 1'b1);
    exp_q.push_back(8'h55);
    send_frame(8'hA3, 1'b1);
    exp_q.push_back(8'hA3);
    clks(20);
    check_bytes("good");
    chk("good_valid_cycles", n_valid_cyc - v0, 2);
    chk("good_ferr", n_ferr - f0, 0);
    chk("good_overrun", n_ovr - o0, 0);

    // False start: 4-clock low pulse, also checks start-detect latency
    v0 = n_valid_cyc; f0 = n_ferr; o0 = n_ovr;
    rx = 1'b0;
    clks(2);
    chk("lat_still_idle", state_dbg, 3'd0);
    clks(1);
    chk("lat_start", state_dbg, 3'd1);
    clks(1);
    rx = 1'b1;
    clks(30);
    chk("false_state", state_dbg, 3'd0);
    chk("false_valid", n_valid_cyc - v0, 0);
    chk("false_ferr", n_ferr - f0, 0);
    chk("false_overrun", n_ovr - o0, 0);

    // Framing error then a clean frame
    v0 = n_valid_cyc; f0 = n_ferr;
    send_frame(8'h3C, 1'b0);
    clks(40);
    chk("ferr_pulses", n_ferr - f0, 1);
    chk("ferr_no_valid", n_valid_cyc - v0, 0);
    chk("ferr_state", state_dbg, 3'd0);
    send_frame(8'h12, 1'b1);
    exp_q.push_back(8'h12);
    clks(20);
    check_bytes("after_ferr");

    // Overrun: two bytes with the consumer stalled
    bus.ready = 1'b0;
    o0 = n_ovr;
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    clks(20);
    chk("ovr_pulses", n_ovr - o0, 1);
    chk("ovr_valid", bus.valid, 1'b1);
    chk("ovr_data", bus.data, 8'h11);
    bus.ready = 1'b1;
    clks(1);
    bus.ready = 1'b0;
    chk("ovr_valid_clear", bus.valid, 1'b0);
    exp_q.push_back(8'h11);
    check_bytes("ovr");
    bus.ready = 1'b1;
    clks(5);

    // Reset in the middle of bit 4 of 0xF0
    v0 = n_valid_cyc; f0 = n_ferr; o0 = n_ovr;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b0);
    rx = 1'b1;
    clks(8);
    reset = 1'b1;
    clks(1);
    chk("midrst_data", bus.data, 8'h00);
    chk("midrst_valid", bus.valid, 1'b0);
    chk("midrst_state", state_dbg, 3'd0);
    reset = 1'b0;
    clks(8);
    for (int i = 5; i < 8; i++) send_bit(1'b1);
    send_bit(1'b1);
    clks(20);
    chk("midrst_no_valid", n_valid_cyc - v0, 0);
    chk("midrst_no_ferr", n_ferr - f0, 0);
    chk("midrst_no_ovr", n_ovr - o0, 0);
    send_frame(8'h81, 1'b1);
    exp_q.push_back(8'h81);
    clks(20);
    check_bytes("after_rst");

`ifdef UART_RX_PARITY_EN
    // Wrong parity bit: byte still delivered alongside perr
    p0 = n_perr; pv0 = n_perr_valid;
    send_frame_par(8'h07, 1'b0);
    exp_q.push_back(8'h07);
    clks(20);
    chk("par_bad_perr", n_perr - p0, 1);
    chk("par_bad_with_valid", n_perr_valid - pv0, 1);
    check_bytes("par_bad");

    // Correct parity bit
    p0 = n_perr;
    send_frame_par(8'h07, 1'b1);
    exp_q.push_back(8'h07);
    clks(20);
    chk("par_good_perr", n_perr - p0, 0);
    check_bytes("par_good");
`else
    p0 = 0; pv0 = 0;
    chk("perr_never", n_perr - p0, 0);
    chk("perr_valid_never", n_perr_valid - pv0, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
